// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, the hardwired zero
// register, and the source/destination register compare helper.
package pipe_pkg;

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MD_BUSY  = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A source field only conflicts when the instruction actually reads it.
    function automatic logic reg_match(input logic       use_src,
                                       input logic [4:0] src,
                                       input logic [4:0] dst);
        return use_src && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over
// increment, and the count sticks at all-ones once reached.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_COUNT)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: load-use and
// mult/div-busy stalls, branch/jump flushes, and stall/flush perf counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LAT  = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_useRs,
    input  logic               id_useRt,
    input  logic               id_useHiLo,
    input  logic               id_mdStart,
    input  logic               ex_memRead,
    input  logic [4:0]         ex_wreg,
    input  logic               ex_branchTkn,
    input  logic               ex_jump,
    input  logic               perf_clr,
    output logic               pc_stall,
    output logic               ifid_stall,
    output logic               ifid_flush,
    output logic               idex_bubble,
    output logic               md_busy,
    output logic               md_done,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count
);

    localparam int              CNT_W    = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LAT - 1);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic load_haz;
    logic md_haz;
    logic stall;
    logic flush;
    logic md_accept;

    // A load writing $zero never produces a value worth waiting for.
    assign load_haz = ex_memRead && (ex_wreg != REG_ZERO) &&
                      (reg_match(id_useRs, id_rs, ex_wreg) ||
                       reg_match(id_useRt, id_rt, ex_wreg));

    assign md_haz    = (state == MD_BUSY) && (id_useHiLo || id_mdStart);
    assign stall     = load_haz || md_haz;
    assign flush     = ex_branchTkn || ex_jump;
    assign md_accept = (state == RUN) && id_mdStart && !stall && !flush;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (md_accept) begin
                    state_nxt = MD_BUSY;
                    cnt_nxt   = CNT_INIT;
                end
            end
            MD_BUSY: begin
                if (cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A flush does not cancel an accepted mult/div: it already left ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Flush wins over stall: the stalled instruction is being squashed anyway.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!rst) begin
            if (flush) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (stall) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end
        end
    end

    assign md_busy = (state == MD_BUSY);
    assign md_done = (state == MD_BUSY) && (cnt == '0);

    sat_counter #(
        .WIDTH (COUNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_stall),
        .clr   (perf_clr),
        .count (stall_count)
    );

    sat_counter #(
        .WIDTH (COUNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ifid_flush),
        .clr   (perf_clr),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: a default instance plus a
// COUNT_W=4 instance sharing the same stimulus for saturation checks.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_useRs;
    logic        id_useRt;
    logic        id_useHiLo;
    logic        id_mdStart;
    logic        ex_memRead;
    logic [4:0]  ex_wreg;
    logic        ex_branchTkn;
    logic        ex_jump;
    logic        perf_clr;

    logic        pc_stall, ifid_stall, ifid_flush, idex_bubble, md_busy, md_done;
    logic [15:0] stall_count, flush_count;
    logic        s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_bubble, s_md_busy, s_md_done;
    logic [3:0]  s_stall_count, s_flush_count;

    int checks_total  = 0;
    int checks_passed = 0;

    hazard_ctrl #(.MD_LAT(4), .COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_useRs(id_useRs), .id_useRt(id_useRt), .id_useHiLo(id_useHiLo),
        .id_mdStart(id_mdStart), .ex_memRead(ex_memRead), .ex_wreg(ex_wreg),
        .ex_branchTkn(ex_branchTkn), .ex_jump(ex_jump), .perf_clr(perf_clr),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .md_busy(md_busy), .md_done(md_done),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_ctrl #(.MD_LAT(4), .COUNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_useRs(id_useRs), .id_useRt(id_useRt), .id_useHiLo(id_useHiLo),
        .id_mdStart(id_mdStart), .ex_memRead(ex_memRead), .ex_wreg(ex_wreg),
        .ex_branchTkn(ex_branchTkn), .ex_jump(ex_jump), .perf_clr(perf_clr),
        .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall), .ifid_flush(s_ifid_flush),
        .idex_bubble(s_idex_bubble), .md_busy(s_md_busy), .md_done(s_md_done),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic mem_rd, input logic [4:0] wreg,
                                 input logic [4:0] rs, input logic use_rs,
                                 input logic [4:0] rt, input logic use_rt,
                                 input logic hilo, input logic md_start,
                                 input logic br, input logic jmp);
        ex_memRead   = mem_rd;
        ex_wreg      = wreg;
        id_rs        = rs;
        id_useRs     = use_rs;
        id_rt        = rt;
        id_useRt     = use_rt;
        id_useHiLo   = hilo;
        id_mdStart   = md_start;
        ex_branchTkn = br;
        ex_jump      = jmp;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkCtrl(input string tag, input logic exp_stall,
                             input logic exp_flush, input logic exp_bubble);
        checkOutput({tag, "_pc_stall"},    32'(pc_stall),    32'(exp_stall));
        checkOutput({tag, "_ifid_stall"},  32'(ifid_stall),  32'(exp_stall));
        checkOutput({tag, "_ifid_flush"},  32'(ifid_flush),  32'(exp_flush));
        checkOutput({tag, "_idex_bubble"}, 32'(idex_bubble), 32'(exp_bubble));
    endtask

    initial begin
        rst = 1'b1;
        perf_clr = 1'b0;
        applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtrl("rst_gate", 1'b0, 1'b0, 1'b0);
        idle();
        tick();
        tick();
        checkOutput("rst_md_busy", 32'(md_busy), 32'd0);
        checkOutput("rst_stall_cnt", 32'(stall_count), 32'd0);
        checkOutput("rst_flush_cnt", 32'(flush_count), 32'd0);
        #2 rst = 1'b0;
        tick();

        $display("[TB] load-use stall");
        applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtrl("lu_rs", 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("lu_stall_cnt1", 32'(stall_count), 32'd1);
        applyStimulus(1'b0, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtrl("lu_release", 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtrl("lu_zero", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd8, 5'd3, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtrl("lu_nomatch", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd8, 5'd8, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtrl("lu_rt", 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("lu_stall_cnt2", 32'(stall_count), 32'd2);

        $display("[TB] mult/div busy");
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCtrl("md_accept", 1'b0, 1'b0, 1'b0);
        checkOutput("md_T_busy", 32'(md_busy), 32'd0);
        tick();
        idle();
        checkOutput("md_T1_busy", 32'(md_busy), 32'd1);
        checkOutput("md_T1_done", 32'(md_done), 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCtrl("md_T2", 1'b1, 1'b0, 1'b1);
        checkOutput("md_T2_done", 32'(md_done), 32'd0);
        tick();
        checkCtrl("md_T3", 1'b1, 1'b0, 1'b1);
        checkOutput("md_T3_done", 32'(md_done), 32'd0);
        tick();
        checkCtrl("md_T4", 1'b1, 1'b0, 1'b1);
        checkOutput("md_T4_busy", 32'(md_busy), 32'd1);
        checkOutput("md_T4_done", 32'(md_done), 32'd1);
        tick();
        checkCtrl("md_T5", 1'b0, 1'b0, 1'b0);
        checkOutput("md_T5_busy", 32'(md_busy), 32'd0);
        checkOutput("md_T5_done", 32'(md_done), 32'd0);
        checkOutput("md_stall_cnt", 32'(stall_count), 32'd5);

        $display("[TB] flush beats stall");
        applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCtrl("fl_branch", 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("fl_flush_cnt", 32'(flush_count), 32'd1);
        checkOutput("fl_stall_cnt", 32'(stall_count), 32'd5);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkCtrl("fl_jump", 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        checkOutput("fl_jump_no_md", 32'(md_busy), 32'd0);
        checkOutput("fl_flush_cnt2", 32'(flush_count), 32'd2);

        $display("[TB] reset mid-op");
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        checkOutput("rm_busy_before", 32'(md_busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rm_busy_async", 32'(md_busy), 32'd0);
        checkOutput("rm_stall_cnt", 32'(stall_count), 32'd0);
        checkOutput("rm_flush_cnt", 32'(flush_count), 32'd0);
        tick();
        #2 rst = 1'b0;
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCtrl("rm_accept", 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("rm_new_busy", 32'(md_busy), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("rm_new_done", 32'(md_busy), 32'd0);

        $display("[TB] counter saturation");
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        checkOutput("sat_small", 32'(s_stall_count), 32'd15);
        checkOutput("sat_wide", 32'(stall_count), 32'd20);
        perf_clr = 1'b1;
        checkCtrl("sat_clr_stall", 1'b1, 1'b0, 1'b1);
        tick();
        perf_clr = 1'b0;
        idle();
        checkOutput("clr_small", 32'(s_stall_count), 32'd0);
        checkOutput("clr_wide", 32'(stall_count), 32'd0);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
